// File: rtl/score_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg
// Shared types and constants for the bit-serial Tetris score accumulator.
//   score_state_t : FSM state encoding (IDLE, ADD, DONE)
//   SCORE_W       : default score/addend width
//   PTS_*LINE     : point values awarded per line-clear event
// ---------------------------------------------------------------------------
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } score_state_t;

  localparam int SCORE_W = 8;

  localparam int PTS_1LINE = 1;
  localparam int PTS_2LINE = 3;
  localparam int PTS_3LINE = 5;
  localparam int PTS_4LINE = 8;

endpackage

// File: rtl/serial_score_adder_fa.sv
// ---------------------------------------------------------------------------
// fullAdder
// Single-bit full adder cell used as the bit slice of the serial accumulator.
// Ports:
//   a, b, cin  : operand bits and carry in
//   sum, cout  : sum bit and carry out
// ---------------------------------------------------------------------------
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_score_adder.sv
// ---------------------------------------------------------------------------
// serial_score_adder
// Bit-serial accumulator for the Tetris score. Adds a per-event point value
// into a running WIDTH-bit score one bit per clock, LSB first, through a
// single fullAdder slice. An add takes WIDTH busy cycles followed by a
// one-cycle done pulse, during which the new score is already visible.
//
// Ports:
//   clk         : system clock, rising edge
//   reset       : asynchronous active-high reset, clears all state
//   clear       : synchronous score clear (new game); aborts any add
//   start       : request to add addend to score (accepted in IDLE or DONE)
//   addend      : points to add, sampled only when start is accepted
//   score       : committed score, changes on completion, clear or reset
//   busy        : high while a serial add is in progress (WIDTH cycles)
//   done        : one-cycle pulse when the new score is committed
//   overflow    : sticky, set on carry out of the MSB
//   dbg_state_o : current FSM state for observation
//
// Handshake: start is a request sampled on every rising edge. It is accepted
// only in IDLE or DONE with clear low; requests in ADD are dropped, not
// queued. Each accepted request produces exactly one done pulse unless
// aborted by clear or reset.
//
// Build option: define SCORE_SATURATE_EN to clamp the score at all ones on
// carry out instead of wrapping modulo 2^WIDTH.
// ---------------------------------------------------------------------------
module serial_score_adder
  import score_pkg::*;
#(
  parameter int WIDTH = SCORE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] addend,
  output logic [WIDTH-1:0] score,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output score_state_t     dbg_state_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  score_state_t     state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;       // score operand, shifted right
  logic [WIDTH-1:0] b_q, b_d;       // addend operand, shifted right
  logic [WIDTH-1:0] res_q, res_d;   // sum bits enter at the MSB
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] score_q, score_d;
  logic             ovf_q, ovf_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] final_sum;

  fullAdder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // On the last bit this is the complete sum: the newest bit lands at the
  // MSB and the earlier WIDTH-1 bits have already shifted down into place.
  assign final_sum = {fa_sum, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      score_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new request directly so back-to-back adds have
        // no dead cycle between them.
        if (start) begin
          a_d     = score_q;
          b_d     = addend;
          res_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end

      ADD: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = final_sum;
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
`ifdef SCORE_SATURATE_EN
          score_d = fa_cout ? '1 : final_sum;
`else
          score_d = final_sum;
`endif
          ovf_d   = ovf_q | fa_cout;
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Clear overrides everything above, including a same-cycle start and
    // the commit of an in-flight add.
    if (clear) begin
      score_d = '0;
      ovf_d   = 1'b0;
      carry_d = 1'b0;
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  assign score       = score_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q == ADD);
  assign done        = (state_q == DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_score_adder.sv
module tb_serial_score_adder;
  import score_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] addend = '0;
  logic [W-1:0] score;
  logic         busy, done, overflow;
  score_state_t dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state: plain integer running sum.
  int ref_score;
  bit ref_ovf;

  serial_score_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .start       (start),
    .addend      (addend),
    .score       (score),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; clear = 1'b0; start = 1'b0; addend = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic void model_add(input int a);
    int s;
    s = ref_score + a;
    if (s >= (1 << W)) begin
      ref_ovf = 1'b1;
`ifdef SCORE_SATURATE_EN
      ref_score = (1 << W) - 1;
`else
      ref_score = s - (1 << W);
`endif
    end else begin
      ref_score = s;
    end
  endfunction

  // ---------------- driver ----------------
  // Issues one add from an idle DUT and waits (bounded) for done. Returns on
  // the negedge of the done cycle with the number of busy cycles seen, the
  // cycle index of done after acceptance and the score seen with done.
  task automatic do_add(input logic [W-1:0] a, output int busy_cyc,
                        output int lat, output bit got_done,
                        output logic [W-1:0] sc);
    @(negedge clk);
    start = 1'b1; addend = a;
    @(negedge clk);
    start = 1'b0;
    addend = W'($urandom);  // must not disturb the add in flight
    busy_cyc = 0; lat = 0; got_done = 1'b0; sc = 'x;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        got_done = 1'b1; sc = score; lat = i;
        break;
      end
      if (busy) busy_cyc++;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    total_cnt++;
    if ({score, busy, done, overflow} !== {{W{1'b0}}, 3'b000})
      $display("FAIL reset_outputs: got score=%0d busy=%b done=%b ovf=%b, want 0 0 0 0",
               score, busy, done, overflow);
    else pass_cnt++;
    total_cnt++;
    if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want IDLE", dbg_state);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int bc, lat; bit gd; logic [W-1:0] sc;
    apply_reset();
    do_add(W'(PTS_3LINE), bc, lat, gd, sc);
    total_cnt++;
    if (!gd) $display("FAIL basic_done: got no done, want done");
    else pass_cnt++;
    total_cnt++;
    if (bc !== W) $display("FAIL basic_busy_cycles: got %0d want %0d", bc, W);
    else pass_cnt++;
    total_cnt++;
    if (lat !== W + 1) $display("FAIL basic_latency: got %0d want %0d", lat, W + 1);
    else pass_cnt++;
    total_cnt++;
    if (sc !== 8'd5 || overflow !== 1'b0)
      $display("FAIL basic_score: got %0d ovf=%b want 5 ovf=0", sc, overflow);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || dbg_state !== IDLE)
      $display("FAIL basic_done_width: got done=%b state=%0d want 0 IDLE", done, dbg_state);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int bc, lat; bit gd; logic [W-1:0] sc, exp_sc;
    apply_reset();
    do_add(8'd200, bc, lat, gd, sc);
    do_add(8'd100, bc, lat, gd, sc);
`ifdef SCORE_SATURATE_EN
    exp_sc = 8'd255;
`else
    exp_sc = 8'd44;
`endif
    total_cnt++;
    if (!gd || sc !== exp_sc || overflow !== 1'b1)
      $display("FAIL overflow_add: got done=%b score=%0d ovf=%b want 1 %0d 1",
               gd, sc, overflow, exp_sc);
    else pass_cnt++;
    // overflow is sticky across a following add without carry
    do_add(8'd0, bc, lat, gd, sc);
    total_cnt++;
    if (sc !== exp_sc || overflow !== 1'b1)
      $display("FAIL overflow_sticky: got score=%0d ovf=%b want %0d 1", sc, overflow, exp_sc);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int dones; bit seen;
    apply_reset();
    dones = 0;
    @(negedge clk);
    start = 1'b1; addend = W'(PTS_2LINE);
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    total_cnt++;
    if (!seen || score !== 8'd3) $display("FAIL b2b_first: got done=%b score=%0d want 1 3", seen, score);
    else pass_cnt++;
    dones++;
    start = 1'b1; addend = W'(PTS_4LINE);  // issued during the DONE cycle
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL b2b_no_gap: got busy=%b done=%b want 1 0", busy, done);
    else pass_cnt++;
    for (int i = 0; i < W + 6; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    total_cnt++;
    if (dones !== 2 || score !== 8'd11)
      $display("FAIL b2b_result: got dones=%0d score=%0d want 2 11", dones, score);
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    int dones;
    apply_reset();
    dones = 0;
    @(negedge clk);
    start = 1'b1; addend = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; addend = 8'd50;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    total_cnt++;
    if (dones !== 1 || score !== 8'd7)
      $display("FAIL busy_ignore: got dones=%0d score=%0d want 1 7", dones, score);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    int bc, lat, dones; bit gd; logic [W-1:0] sc;
    apply_reset();
    do_add(8'd200, bc, lat, gd, sc);
    do_add(8'd100, bc, lat, gd, sc);
    @(negedge clk);
    start = 1'b1; addend = 8'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total_cnt++;
    if (score !== '0 || overflow !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE)
      $display("FAIL clear_mid_add: got score=%0d ovf=%b busy=%b state=%0d want 0 0 0 IDLE",
               score, overflow, busy, dbg_state);
    else pass_cnt++;
    dones = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    total_cnt++;
    if (dones !== 0 || score !== '0) $display("FAIL clear_no_done: got dones=%0d score=%0d want 0 0", dones, score);
    else pass_cnt++;

    // clear and start together: clear wins, start dropped
    do_add(8'd9, bc, lat, gd, sc);
    @(negedge clk);
    clear = 1'b1; start = 1'b1; addend = 8'd20;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || score !== '0 || dbg_state !== IDLE)
      $display("FAIL clear_start: got busy=%b score=%0d state=%0d want 0 0 IDLE", busy, score, dbg_state);
    else pass_cnt++;
    dones = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    total_cnt++;
    if (dones !== 0 || score !== '0) $display("FAIL clear_start_no_done: got dones=%0d score=%0d want 0 0", dones, score);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int bc, lat; bit gd; logic [W-1:0] sc;
    apply_reset();
    do_add(8'd200, bc, lat, gd, sc);
    do_add(8'd100, bc, lat, gd, sc);
    @(negedge clk);
    start = 1'b1; addend = 8'd33;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;  // between edges: must act without a clock
    #1;
    total_cnt++;
    if ({score, busy, done, overflow} !== {{W{1'b0}}, 3'b000} || dbg_state !== IDLE)
      $display("FAIL async_reset: got score=%0d busy=%b done=%b ovf=%b state=%0d want 0 0 0 0 IDLE",
               score, busy, done, overflow, dbg_state);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    int bc, lat; bit gd; logic [W-1:0] sc, a;
    apply_reset();
    ref_score = 0; ref_ovf = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      a = (n % 10 == 0) ? 8'd0 : W'($urandom_range(0, 255));
      do_add(a, bc, lat, gd, sc);
      model_add(int'(a));
      total_cnt++;
      if (!gd || sc !== W'(ref_score) || overflow !== ref_ovf || bc !== W)
        $display("FAIL random_add[%0d]: addend=%0d got done=%b score=%0d ovf=%b busy=%0d want 1 %0d %b %0d",
                 n, a, gd, sc, overflow, bc, ref_score, ref_ovf, W);
      else pass_cnt++;
    end
    do_add(8'd0, bc, lat, gd, sc);
    total_cnt++;
    if (!gd || sc !== W'(ref_score))
      $display("FAIL zero_addend: got done=%b score=%0d want 1 %0d", gd, sc, ref_score);
    else pass_cnt++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_start_while_busy();
    test_clear();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
